// File: rtl/pds_pkg.sv
// rtl/pds_pkg.sv - shared types, default sizes and request decode for the push-down stack
package pds_pkg;

    localparam int PDS_DATAWIDTH = 8;
    localparam int PDS_ADDRWIDTH = 10;

    typedef enum logic [2:0] {
        PDS_NOP,
        PDS_PUSH,
        PDS_POP,
        PDS_SWAP,
        PDS_PASS,
        PDS_FLUSH
    } pds_op_e;

    // Illegal requests (push when full, pop when empty) decode to NOP so storage and pointer stay put.
    function automatic pds_op_e pds_decode(input logic flush, input logic push, input logic pop,
                                           input logic empty, input logic full);
        pds_op_e op;
        op = PDS_NOP;
        if (flush)
            op = PDS_FLUSH;
        else if (push && !pop)
            op = full ? PDS_NOP : PDS_PUSH;
        else if (pop && !push)
            op = empty ? PDS_NOP : PDS_POP;
        else if (push && pop)
            op = empty ? PDS_PASS : PDS_SWAP;
        return op;
    endfunction

endpackage

// File: rtl/pds_stack_ctrl_if.sv
// rtl/pds_stack_ctrl_if.sv - request/response bundle between the datapath and the stack controller
interface pds_stack_ctrl_if
    import pds_pkg::*;
#(
    parameter int DATAWIDTH = PDS_DATAWIDTH,
    parameter int ADDRWIDTH = PDS_ADDRWIDTH
);
    logic                 Push;
    logic                 Pop;
    logic                 Flush;
    logic [DATAWIDTH-1:0] DIn;
    logic [DATAWIDTH-1:0] DOut;
    logic                 DValid;
    logic                 Full;
    logic                 Empty;
    logic [ADDRWIDTH:0]   Count;
    logic                 Ovf;
    logic                 Udf;

    modport master (
        output Push, Pop, Flush, DIn,
        input  DOut, DValid, Full, Empty, Count, Ovf, Udf
    );

    modport slave (
        input  Push, Pop, Flush, DIn,
        output DOut, DValid, Full, Empty, Count, Ovf, Udf
    );
endinterface

// File: rtl/pds_mem.sv
// rtl/pds_mem.sv - stack storage: one synchronous write port, one registered read port with bypass
module pds_mem #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 10
) (
    input  logic                 Clk,
    input  logic                 ClrN,
    input  logic                 we,
    input  logic [ADDRWIDTH-1:0] waddr,
    input  logic [DATAWIDTH-1:0] wdata,
    input  logic                 rd_en,
    input  logic                 rd_bypass,
    input  logic [ADDRWIDTH-1:0] raddr,
    output logic [DATAWIDTH-1:0] rdata
);
    localparam int DEPTH = 1 << ADDRWIDTH;

    logic [DATAWIDTH-1:0] mem [0:DEPTH-1];

    always_ff @(posedge Clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    // Read-before-write on a swap: rdata takes the old entry at the same address being overwritten.
    always_ff @(posedge Clk or negedge ClrN) begin
        if (!ClrN)
            rdata <= '0;
        else if (rd_en)
            rdata <= rd_bypass ? wdata : mem[raddr];
    end
endmodule

// File: rtl/pds_stack_ctrl.sv
// rtl/pds_stack_ctrl.sv - push-down stack controller; PDS_ERR_FLAGS_EN enables sticky Ovf/Udf flags
module pds_stack_ctrl
    import pds_pkg::*;
#(
    parameter int DATAWIDTH = PDS_DATAWIDTH,
    parameter int ADDRWIDTH = PDS_ADDRWIDTH
) (
    input logic              Clk,
    input logic              ClrN,
    pds_stack_ctrl_if.slave  bus
);
    localparam int                 DEPTH      = 1 << ADDRWIDTH;
    localparam logic [ADDRWIDTH:0] FULL_COUNT = (ADDRWIDTH + 1)'(DEPTH);
    localparam logic [ADDRWIDTH:0] ONE_C      = (ADDRWIDTH + 1)'(1);
    localparam logic [ADDRWIDTH-1:0] ONE_A    = ADDRWIDTH'(1);

    logic [ADDRWIDTH:0]   count;
    logic                 empty;
    logic                 full;
    logic                 dvalid;
    logic                 ovf;
    logic                 udf;
    pds_op_e              op;
    logic [ADDRWIDTH-1:0] top_addr;
    logic [ADDRWIDTH-1:0] waddr;
    logic                 we;
    logic                 rd_en;

    assign empty    = (count == '0);
    assign full     = (count == FULL_COUNT);
    assign op       = pds_decode(bus.Flush, bus.Push, bus.Pop, empty, full);

    // At DEPTH the low bits are zero, so the subtraction wraps to DEPTH-1, which is the top entry.
    assign top_addr = count[ADDRWIDTH-1:0] - ONE_A;
    assign waddr    = (op == PDS_PUSH) ? count[ADDRWIDTH-1:0] : top_addr;
    assign we       = (op == PDS_PUSH) || (op == PDS_SWAP);
    assign rd_en    = (op == PDS_POP) || (op == PDS_SWAP) || (op == PDS_PASS);

    pds_mem #(
        .DATAWIDTH (DATAWIDTH),
        .ADDRWIDTH (ADDRWIDTH)
    ) u_mem (
        .Clk       (Clk),
        .ClrN      (ClrN),
        .we        (we),
        .waddr     (waddr),
        .wdata     (bus.DIn),
        .rd_en     (rd_en),
        .rd_bypass (op == PDS_PASS),
        .raddr     (top_addr),
        .rdata     (bus.DOut)
    );

    always_ff @(posedge Clk or negedge ClrN) begin
        if (!ClrN) begin
            count  <= '0;
            dvalid <= 1'b0;
        end else begin
            dvalid <= rd_en;
            case (op)
                PDS_FLUSH: count <= '0;
                PDS_PUSH:  count <= count + ONE_C;
                PDS_POP:   count <= count - ONE_C;
                default:   count <= count;
            endcase
        end
    end

`ifdef PDS_ERR_FLAGS_EN
    logic ovf_evt;
    logic udf_evt;

    assign ovf_evt = !bus.Flush && bus.Push && !bus.Pop && full;
    assign udf_evt = !bus.Flush && bus.Pop && !bus.Push && empty;

    always_ff @(posedge Clk or negedge ClrN) begin
        if (!ClrN) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else if (bus.Flush) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            ovf <= ovf | ovf_evt;
            udf <= udf | udf_evt;
        end
    end
`else
    assign ovf = 1'b0;
    assign udf = 1'b0;
`endif

    assign bus.Count  = count;
    assign bus.Full   = full;
    assign bus.Empty  = empty;
    assign bus.DValid = dvalid;
    assign bus.Ovf    = ovf;
    assign bus.Udf    = udf;
endmodule

// File: tb/tb_pds_stack_ctrl.sv
// tb/tb_pds_stack_ctrl.sv - scoreboard bench for pds_stack_ctrl against a queue-based stack model
module tb_pds_stack_ctrl;
    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    typedef struct {
        int count;
        bit dv;
        bit ovf;
        bit udf;
    } st_t;

    logic Clk = 1'b0;
    logic ClrN;
    always #5 Clk = ~Clk;

    pds_stack_ctrl_if #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) bus();

    pds_stack_ctrl #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) dut (
        .Clk  (Clk),
        .ClrN (ClrN),
        .bus  (bus)
    );

    int  vectors = 0;
    int  miscompares = 0;
    int  stk[$];
    st_t stq[$];
    int  dq[$];
    bit  ovf_m = 1'b0;
    bit  udf_m = 1'b0;
    bit  mon_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One request cycle: drive at negedge, advance the reference stack, queue what the DUT must show.
    task automatic step(input bit push, input bit pop, input bit flush, input logic [DW-1:0] din);
        int exp_d = 0;
        bit dv = 1'b0;
        @(negedge Clk);
        bus.Push  = push;
        bus.Pop   = pop;
        bus.Flush = flush;
        bus.DIn   = din;
        if (flush) begin
            stk.delete();
            ovf_m = 1'b0;
            udf_m = 1'b0;
        end else if (push && !pop) begin
            if (stk.size() < DEPTH) stk.push_back(int'(din));
`ifdef PDS_ERR_FLAGS_EN
            else ovf_m = 1'b1;
`endif
        end else if (pop && !push) begin
            if (stk.size() > 0) begin
                exp_d = stk.pop_back();
                dv = 1'b1;
            end
`ifdef PDS_ERR_FLAGS_EN
            else udf_m = 1'b1;
`endif
        end else if (push && pop) begin
            dv = 1'b1;
            if (stk.size() > 0) begin
                exp_d = stk[$];
                stk[stk.size() - 1] = int'(din);
            end else begin
                exp_d = int'(din);
            end
        end
        if (mon_en) begin
            stq.push_back('{stk.size(), dv, ovf_m, udf_m});
            if (dv) dq.push_back(exp_d);
        end
    endtask

    always @(posedge Clk) begin
        st_t st;
        #1;
        if (mon_en && stq.size() > 0) begin
            st = stq.pop_front();
            check("count",  int'(bus.Count),  st.count);
            check("full",   int'(bus.Full),   int'(st.count == DEPTH));
            check("empty",  int'(bus.Empty),  int'(st.count == 0));
            check("dvalid", int'(bus.DValid), int'(st.dv));
            check("ovf",    int'(bus.Ovf),    int'(st.ovf));
            check("udf",    int'(bus.Udf),    int'(st.udf));
            if (bus.DValid && dq.size() > 0)
                check("dout", int'(bus.DOut), dq.pop_front());
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count"},  int'(bus.Count),  0);
        check({tag, "_dout"},   int'(bus.DOut),   0);
        check({tag, "_dvalid"}, int'(bus.DValid), 0);
        check({tag, "_empty"},  int'(bus.Empty),  1);
        check({tag, "_full"},   int'(bus.Full),   0);
        check({tag, "_ovf"},    int'(bus.Ovf),    0);
        check({tag, "_udf"},    int'(bus.Udf),    0);
    endtask

    initial begin
        ClrN      = 1'b0;
        bus.Push  = 1'b0;
        bus.Pop   = 1'b0;
        bus.Flush = 1'b0;
        bus.DIn   = '0;
        @(posedge Clk);
        #1;
        check_reset_outputs("reset");
        @(negedge Clk);
        ClrN   = 1'b1;
        mon_en = 1'b1;

        // Fill, overflow, drain, underflow
        step(1, 0, 0, 8'h11);
        step(1, 0, 0, 8'h22);
        step(1, 0, 0, 8'h33);
        step(1, 0, 0, 8'h44);
        step(1, 0, 0, 8'h55);
        step(0, 0, 0, 8'h00);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 8'h00);
        step(0, 1, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        step(0, 0, 1, 8'h00);

        // Swap at depth 2, then pass-through when empty
        step(1, 0, 0, 8'hA0);
        step(1, 0, 0, 8'hA1);
        step(1, 1, 0, 8'hB0);
        step(0, 1, 0, 8'h00);
        step(0, 1, 0, 8'h00);
        step(1, 1, 0, 8'h7E);

        // Flush dominates a simultaneous push at depth 3
        step(1, 0, 0, 8'h01);
        step(1, 0, 0, 8'h02);
        step(1, 0, 0, 8'h03);
        step(1, 0, 1, 8'h04);
        step(0, 0, 0, 8'h00);

        // Randomized traffic, biased so the stack regularly hits both ends
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 3)       step(0, 0, 1, 8'($urandom));
            else if (r < 45) step(1, 0, 0, 8'($urandom));
            else if (r < 80) step(0, 1, 0, 8'($urandom));
            else if (r < 92) step(1, 1, 0, 8'($urandom));
            else             step(0, 0, 0, 8'($urandom));
        end

        // Asynchronous reset in the middle of a pop burst
        step(0, 0, 1, 8'h00);
        step(1, 0, 0, 8'hC1);
        step(1, 0, 0, 8'hC2);
        step(1, 0, 0, 8'hC3);
        step(0, 1, 0, 8'h00);
        step(0, 1, 0, 8'h00);
        @(posedge Clk);
        #2;
        mon_en = 1'b0;
        ClrN   = 1'b0;
        #1;
        check_reset_outputs("midreset");
        stq.delete();
        dq.delete();
        stk.delete();
        ovf_m     = 1'b0;
        udf_m     = 1'b0;
        bus.Push  = 1'b0;
        bus.Pop   = 1'b0;
        bus.Flush = 1'b0;
        @(negedge Clk);
        ClrN   = 1'b1;
        mon_en = 1'b1;

        step(1, 0, 0, 8'h5A);
        step(0, 1, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        repeat (3) @(posedge Clk);
        #2;
        check("drain_status", stq.size(), 0);
        check("drain_data",   dq.size(),  0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
